mul_div_iter: RTL

//  Iterative 32x32 multiply/divide unit for the ALU's HI/LO path. Accepts one operation
//  per start pulse and computes it over WIDTH cycles. Produces a 64-bit {hi,lo} result

---
 rtl/mul_div_iter_pkg.sv | 6 +
 rtl/mul_div_iter_twos_neg.sv | 8 +
 rtl/mul_div_iter.sv | 75 +++++++
 3 files changed

// File: rtl/mul_div_iter_pkg.sv
// mul_div_iter_pkg: shared op codes and FSM encoding for the iterative mul/div unit
package mul_div_iter_pkg;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
endpackage

// File: rtl/mul_div_iter_twos_neg.sv
// twos_neg: combinational conditional two's-complement negate (wrapping)
module twos_neg #(parameter int W = 32) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  assign y = neg ? -x : x;
endmodule

// File: rtl/mul_div_iter.sv
// mul_div_iter: iterative WIDTH-cycle shift-add multiply / restoring divide, {hi,lo} result
module mul_div_iter import mul_div_iter_pkg::*; #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic               sign,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] res,
  output logic               div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic op_r, nsgn, rsgn, dbz;
  logic [WIDTH-1:0] opd, abs_a, abs_b, q_fix, r_fix;
  logic [2*WIDTH:0] acc, acc_nxt;
  logic [2*WIDTH-1:0] p_fix;
  logic [WIDTH:0] msum, rem_sh;
  logic [WIDTH+1:0] diff;
  assign busy = state != IDLE;
  twos_neg #(WIDTH) u_abs_a (.neg(sign && a[WIDTH-1]), .x(a), .y(abs_a));
  twos_neg #(WIDTH) u_abs_b (.neg(sign && b[WIDTH-1]), .x(b), .y(abs_b));
  twos_neg #(2*WIDTH) u_fix_p (.neg(nsgn), .x(acc[2*WIDTH-1:0]), .y(p_fix));
  // divide-by-zero keeps the all-ones quotient untouched
  twos_neg #(WIDTH) u_fix_q (.neg(nsgn && !dbz), .x(acc[WIDTH-1:0]), .y(q_fix));
  twos_neg #(WIDTH) u_fix_r (.neg(rsgn), .x(acc[2*WIDTH-1:WIDTH]), .y(r_fix));
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) :
          state == RUN  ? (cnt == CW'(WIDTH - 1) ? FIX : RUN) : IDLE;
    msum = acc[2*WIDTH:WIDTH] + {1'b0, acc[0] ? opd : '0};
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff = {1'b0, rem_sh} - {2'b0, opd};
    acc_nxt = op_r == OP_DIV ?
              (diff[WIDTH+1] ? {rem_sh, acc[WIDTH-2:0], 1'b0} : {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1}) :
              {1'b0, msum, acc[WIDTH-1:1]};
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      op_r <= 1'b0;
      nsgn <= 1'b0;
      rsgn <= 1'b0;
      dbz <= 1'b0;
      opd <= '0;
      acc <= '0;
      done <= 1'b0;
      res <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= state == FIX;
      cnt <= state == RUN ? cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        op_r <= op;
        nsgn <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
        rsgn <= sign && a[WIDTH-1];
        dbz <= op == OP_DIV && b == '0;
        opd <= op == OP_MUL ? abs_a : abs_b;
        acc <= {{(WIDTH+1){1'b0}}, op == OP_MUL ? abs_b : abs_a};
        div_by_zero <= 1'b0;
      end
      if (state == RUN) acc <= acc_nxt;
      if (state == FIX) begin
        res <= op_r == OP_DIV ? {r_fix, q_fix} : p_fix;
        div_by_zero <= dbz;
      end
    end
  end
endmodule
